// File: rtl/cdr_vote_filter.sv
// Clock-data-recovery phase picker: early/late votes from a phase detector are
// integrated, and reaching +/-THRESH steps the sampling phase with hold-off and lock tracking.
module cdr_vote_filter #(
  parameter int THRESH   = 8,
  parameter int HOLDOFF  = 2,
  parameter int LOCK_LEN = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_T,
  input  logic       i_E,
  input  logic [5:0] i_nb_P,
  output logic [5:0] o_phase_sel,
  output logic       o_adv,
  output logic       o_ret,
  output logic       o_lock
);

  typedef enum logic {TRACK, HOLD} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  localparam logic signed [5:0] VMAX = 6'(THRESH - 1);
  localparam logic signed [5:0] VMIN = -VMAX;
  localparam logic [5:0]        LMAX = 6'(LOCK_LEN);
  localparam logic [2:0]        HLAST = 3'(HOLDOFF - 1);

  state_t            state_q, state_d;
  dir_t              last_q, last_d;
  logic signed [5:0] vcnt_q, vcnt_d;
  logic [2:0]        hcnt_q, hcnt_d;
  logic [5:0]        lcnt_q, lcnt_d;
  logic [5:0]        phase_d;
  logic              adv_d, ret_d, lock_d;
  logic              up, dn, vote, hit_up, hit_dn;

  always_comb begin
    up     = i_valid & i_T & i_E;
    dn     = i_valid & i_T & ~i_E;
    vote   = (state_q == TRACK) & (up | dn);
    hit_up = vote & up & (vcnt_q == VMAX);
    hit_dn = vote & dn & (vcnt_q == VMIN);

    state_d = state_q;
    last_d  = last_q;
    vcnt_d  = vcnt_q;
    hcnt_d  = hcnt_q;
    lcnt_d  = lcnt_q;
    phase_d = o_phase_sel;
    adv_d   = 1'b0;
    ret_d   = 1'b0;

    if (vote) begin
      if (lcnt_q != LMAX) lcnt_d = lcnt_q + 6'd1;
      vcnt_d = up ? vcnt_q + 6'sd1 : vcnt_q - 6'sd1;
    end

    if (hit_up | hit_dn) begin
      vcnt_d = '0;
      // A repeat of the previous direction means we are still chasing: drop lock.
      if ((hit_up && last_q == DIR_UP) || (hit_dn && last_q == DIR_DN)) lcnt_d = '0;
      last_d = hit_up ? DIR_UP : DIR_DN;
      if (HOLDOFF != 0) begin
        state_d = HOLD;
        hcnt_d  = '0;
      end
    end

    if (state_q == HOLD && i_valid) begin
      if (hcnt_q == HLAST) state_d = TRACK;
      else                 hcnt_d  = hcnt_q + 3'd1;
    end

    // Degenerate or shrunk modulus overrides any step, silently.
    if (i_nb_P <= 6'd1 || o_phase_sel >= i_nb_P) begin
      phase_d = '0;
    end else if (hit_up) begin
      adv_d   = 1'b1;
      phase_d = (o_phase_sel == i_nb_P - 6'd1) ? 6'd0 : o_phase_sel + 6'd1;
    end else if (hit_dn) begin
      ret_d   = 1'b1;
      phase_d = (o_phase_sel == 6'd0) ? i_nb_P - 6'd1 : o_phase_sel - 6'd1;
    end

    lock_d = (lcnt_d == LMAX);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= TRACK;
      last_q      <= DIR_NONE;
      vcnt_q      <= '0;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      o_phase_sel <= '0;
      o_adv       <= 1'b0;
      o_ret       <= 1'b0;
      o_lock      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      vcnt_q      <= vcnt_d;
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      o_phase_sel <= phase_d;
      o_adv       <= adv_d;
      o_ret       <= ret_d;
      o_lock      <= lock_d;
    end
  end

endmodule

// File: tb/tb_cdr_vote_filter.sv
// Directed and randomized checks of cdr_vote_filter against a behavioural vote/step model.
module tb_cdr_vote_filter;
  localparam int THRESH = 8, HOLDOFF = 2, LOCK_LEN = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1, valid = 1'b0, tt = 1'b0, ee = 1'b0;
  logic [5:0] nb = 6'd10;
  logic [5:0] o_phase_sel;
  logic       o_adv, o_ret, o_lock;

  int total = 0, bad = 0;
  // reference model state
  int m_vcnt, m_hold, m_phase, m_lock, m_last;
  bit m_adv, m_ret;

  always #10 clk = ~clk;

  cdr_vote_filter #(.THRESH(THRESH), .HOLDOFF(HOLDOFF), .LOCK_LEN(LOCK_LEN)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_T(tt), .i_E(ee), .i_nb_P(nb),
    .o_phase_sel(o_phase_sel), .o_adv(o_adv), .o_ret(o_ret), .o_lock(o_lock));

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit t, input bit e);
    int d, nbi, old;
    bit step;
    nbi = int'(nb);
    old = m_phase;
    m_adv = 0; m_ret = 0; step = 0; d = 0;
    if (r) begin
      m_vcnt = 0; m_hold = 0; m_phase = 0; m_lock = 0; m_last = 0;
      return;
    end
    if (v) begin
      if (m_hold > 0) m_hold--;
      else if (t) begin
        d = e ? 1 : -1;
        m_vcnt += d;
        if (m_lock < LOCK_LEN) m_lock++;
        if (m_vcnt == THRESH || m_vcnt == -THRESH) begin
          step = 1;
          m_vcnt = 0;
          m_hold = HOLDOFF;
          if (m_last == d) m_lock = 0;
          m_last = d;
        end
      end
    end
    if (nbi <= 1 || old >= nbi) m_phase = 0;
    else if (step) begin
      if (d > 0) begin m_adv = 1; m_phase = (old + 1) % nbi; end
      else       begin m_ret = 1; m_phase = (old + nbi - 1) % nbi; end
    end
  endtask

  task automatic tick(input bit r, input bit v, input bit t, input bit e);
    rst = r; valid = v; tt = t; ee = e;
    @(posedge clk);
    model(r, v, t, e);
    #1;
    chk("phase_sel", int'(o_phase_sel), m_phase);
    chk("adv", int'(o_adv), int'(m_adv));
    chk("ret", int'(o_ret), int'(m_ret));
    chk("lock", int'(o_lock), int'(m_lock == LOCK_LEN));
    chk("adv_ret_excl", int'(o_adv & o_ret), 0);
  endtask

  task automatic votes(input int n, input bit t, input bit e);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, t, e);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_vcnt = 0; m_hold = 0; m_phase = 0; m_lock = 0; m_last = 0;

    // reset state
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_phase", int'(o_phase_sel), 0);
    chk("rst_lock", int'(o_lock), 0);
    chk("rst_vcnt", int'(dut.vcnt_q), 0);

    // 8 up votes -> advance 0 -> 1 one cycle after the 8th strobe
    nb = 6'd10;
    votes(7, 1'b1, 1'b1);
    chk("no_adv_at_7", int'(o_adv), 0);
    votes(1, 1'b1, 1'b1);
    chk("adv_at_8", int'(o_adv), 1);
    chk("phase_after_adv", int'(o_phase_sel), 1);
    chk("vcnt_after_adv", int'(dut.vcnt_q), 0);

    // two strobes ignored in hold, then 8 more votes for the next step
    votes(9, 1'b1, 1'b1);
    chk("no_adv_at_9_after", int'(o_adv), 0);
    votes(1, 1'b1, 1'b1);
    chk("adv_at_10_after", int'(o_adv), 1);
    chk("phase_after_2nd", int'(o_phase_sel), 2);

    // 8 down votes from phase 0 wrap to 9
    do_reset();
    votes(8, 1'b1, 1'b0);
    chk("ret_at_8", int'(o_ret), 1);
    chk("phase_wrap_dn", int'(o_phase_sel), 9);

    // 9 -> 0 on increment wrap
    votes(2, 1'b0, 1'b0);
    votes(8, 1'b1, 1'b1);
    chk("phase_wrap_up", int'(o_phase_sel), 0);

    // balanced votes and idle strobes: no step, no lock
    do_reset();
    votes(5, 1'b1, 1'b1);
    votes(5, 1'b1, 1'b0);
    votes(20, 1'b0, 1'b1);
    chk("bal_vcnt", int'(dut.vcnt_q), 0);
    chk("bal_lock", int'(o_lock), 0);
    chk("bal_phase", int'(o_phase_sel), 0);

    // dither locks; two same-direction steps break lock
    do_reset();
    for (int k = 0; k < 4; k++) begin
      votes(8, 1'b1, (k % 2) == 0);
      votes(2, 1'b0, 1'b0);
    end
    chk("dither_lock", int'(o_lock), 1);
    votes(8, 1'b1, 1'b1);
    chk("first_adv_keeps_lock", int'(o_lock), 1);
    votes(2, 1'b0, 1'b0);
    votes(8, 1'b1, 1'b1);
    chk("repeat_adv_pulse", int'(o_adv), 1);
    chk("repeat_adv_unlock", int'(o_lock), 0);

    // reset wins over the threshold-reaching vote
    do_reset();
    votes(7, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rstwin_adv", int'(o_adv), 0);
    chk("rstwin_phase", int'(o_phase_sel), 0);
    chk("rstwin_lock", int'(o_lock), 0);
    chk("rstwin_ret", int'(o_ret), 0);

    // shrinking modulus forces phase 0 without a pulse
    do_reset();
    votes(8, 1'b1, 1'b0);
    votes(2, 1'b0, 1'b0);
    nb = 6'd5;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("shrink_phase", int'(o_phase_sel), 0);

    // modulus 1 suppresses steps
    nb = 6'd1;
    votes(8, 1'b1, 1'b1);
    chk("nb1_no_adv", int'(o_adv), 0);
    chk("nb1_phase", int'(o_phase_sel), 0);

    // randomized traffic with biased direction segments
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int bias;
      bit r;
      if (c % 250 == 0) nb = 6'($urandom_range(0, 20));
      bias = ((c / 120) % 2 == 0) ? 80 : 25;
      r = ($urandom_range(0, 599) == 0);
      tick(r, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < bias);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
